// File: rtl/rmc_result_drain_pkg.sv
// Shared types and the lane shift/saturate arithmetic for the result drain.
package rmc_result_drain_pkg;

    // Working width for the lane arithmetic; wide enough for any legal lane width.
    localparam int CALC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Arithmetic right shift followed by clamping to a signed res_w-bit range.
    // sat reports whether clamping was applied.
    function automatic logic signed [CALC_W-1:0] sat_shift(
        input  logic signed [CALC_W-1:0] x,
        input  int                       shift,
        input  int                       res_w,
        output logic                     sat
    );
        logic signed [CALC_W-1:0] y;
        logic signed [CALC_W-1:0] maxv;
        logic signed [CALC_W-1:0] minv;
        y    = x >>> shift;
        maxv = (64'sd1 <<< (res_w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (res_w - 1));
        sat  = 1'b1;
        if (y > maxv) begin
            sat_shift = maxv;
        end else if (y < minv) begin
            sat_shift = minv;
        end else begin
            sat_shift = y;
            sat       = 1'b0;
        end
    endfunction

endpackage

// File: rtl/rmc_result_drain_if.sv
// Result-side bus: lane stream (valid/ready) plus the result BRAM write port.
interface rmc_result_drain_if #(
    parameter int NUM_LANES = 8,
    parameter int RES_WIDTH = 8,
    parameter int RES_DEPTH = 64
) ();
    localparam int ADDR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    logic                              M_VALID;
    logic                              M_READY;
    logic signed [RES_WIDTH-1:0]       M_DATA;
    logic                              M_LAST;
    logic                              WR_EN;
    logic [ADDR_W-1:0]                 WR_ADDR;
    logic [NUM_LANES*RES_WIDTH-1:0]    WR_DATA;

    modport master (
        output M_VALID, M_DATA, M_LAST, WR_EN, WR_ADDR, WR_DATA,
        input  M_READY
    );

    modport slave (
        input  M_VALID, M_DATA, M_LAST, WR_EN, WR_ADDR, WR_DATA,
        output M_READY
    );
endinterface

// File: rtl/rmc_result_drain_lane_sat.sv
// One accumulator lane: arithmetic right shift then saturate to the result width.
module rmc_lane_sat
    import rmc_result_drain_pkg::*;
#(
    parameter int DSPOUT_WIDTH = 16,
    parameter int RES_WIDTH    = 8,
    parameter int SHIFT        = 0
) (
    input  logic signed [DSPOUT_WIDTH-1:0] i_lane,
    output logic signed [RES_WIDTH-1:0]    o_res,
    output logic                           o_sat
);
    logic w_sat;

    // Sign-extend to the working width, shift, clamp and narrow.
    always_comb begin
        w_sat = 1'b0;
        o_res = RES_WIDTH'(sat_shift(CALC_W'(i_lane), SHIFT, RES_WIDTH, w_sat));
        o_sat = w_sat;
    end
endmodule

// File: rtl/rmc_result_drain.sv
// Result drain: captures the PU accumulator row on the DONE rising edge,
// streams the saturated lanes one per handshake, then writes the row to BRAM.
module rmc_result_drain
    import rmc_result_drain_pkg::*;
#(
    parameter int NUM_LANES    = 8,
    parameter int DSPOUT_WIDTH = 16,
    parameter int RES_WIDTH    = 8,
    parameter int SHIFT        = 0,
    parameter int RES_DEPTH    = 64
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic                              PU_DONE,
    input  logic [NUM_LANES*DSPOUT_WIDTH-1:0] PU_OUT,
    input  logic                              CLR,
    rmc_result_drain_if.master                m_if,
    output logic                              BUSY,
    output logic                              SAT_FLAG,
    output logic                              DROP_ERR
);
    localparam int ADDR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RES_DEPTH - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_t                         r_state;
    state_t                         w_next;
    logic                           r_done_d;
    logic [LANE_W-1:0]              r_lane;
    logic [ADDR_W-1:0]              r_addr;
    logic                           r_sat;
    logic                           r_drop;
    logic [NUM_LANES*RES_WIDTH-1:0] r_row;
    logic [NUM_LANES*RES_WIDTH-1:0] w_row_sat;
    logic [NUM_LANES-1:0]           w_lane_sat;
    logic                           w_done_rise;
    logic                           w_last;
    logic                           w_capture;
    logic                           w_advance;
    logic                           w_write;
    logic                           w_drop;

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        rmc_lane_sat #(
            .DSPOUT_WIDTH (DSPOUT_WIDTH),
            .RES_WIDTH    (RES_WIDTH),
            .SHIFT        (SHIFT)
        ) u_sat (
            .i_lane (PU_OUT[j*DSPOUT_WIDTH +: DSPOUT_WIDTH]),
            .o_res  (w_row_sat[j*RES_WIDTH +: RES_WIDTH]),
            .o_sat  (w_lane_sat[j])
        );
    end

    assign w_done_rise = PU_DONE & ~r_done_d;
    assign w_last      = (r_lane == LAST_LANE);

    // Next-state logic; a DONE rise outside IDLE is dropped and flagged.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_advance = 1'b0;
        w_write   = 1'b0;
        w_drop    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_done_rise) begin
                    w_capture = 1'b1;
                    w_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                w_drop = w_done_rise;
                if (m_if.M_READY) begin
                    if (w_last) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                w_drop  = w_done_rise;
                w_write = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE edge detector, lane counter and wrapping write address.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_done_d <= 1'b0;
            r_lane   <= '0;
            r_addr   <= '0;
        end else begin
            r_done_d <= PU_DONE;
            if (w_capture) begin
                r_lane <= '0;
            end else if (w_advance) begin
                r_lane <= r_lane + 1'b1;
            end
            if (w_write) begin
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
            end
        end
    end

    // Sticky flags; a set event in the same cycle as CLR wins.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_sat  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (w_capture && (|w_lane_sat)) begin
                r_sat <= 1'b1;
            end else if (CLR) begin
                r_sat <= 1'b0;
            end
            if (w_drop) begin
                r_drop <= 1'b1;
            end else if (CLR) begin
                r_drop <= 1'b0;
            end
        end
    end

    // Row holding register; outputs are gated by state so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_row <= w_row_sat;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        m_if.M_VALID = (r_state == ST_SEND);
        m_if.M_LAST  = (r_state == ST_SEND) && w_last;
        m_if.M_DATA  = '0;
        if (r_state == ST_SEND) begin
            m_if.M_DATA = r_row[r_lane*RES_WIDTH +: RES_WIDTH];
        end
        m_if.WR_EN   = (r_state == ST_WRITE);
        m_if.WR_ADDR = r_addr;
        m_if.WR_DATA = (r_state == ST_WRITE) ? r_row : '0;
        BUSY         = (r_state != ST_IDLE);
        SAT_FLAG     = r_sat;
        DROP_ERR     = r_drop;
    end
endmodule

// File: tb/tb_rmc_result_drain.sv
// Bench for rmc_result_drain: two instances (SHIFT=0/RES_DEPTH=4 and
// SHIFT=4/RES_DEPTH=64) share the stimulus; a scoreboard holds expected lanes and writes.
module tb_rmc_result_drain;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } lane_t;

    typedef struct packed {
        logic [1:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic         CLK;
    logic         RSTN;
    logic         PU_DONE;
    logic [127:0] PU_OUT;
    logic         CLR;
    logic         busy_a, sat_a, drop_a;
    logic         busy_b, sat_b, drop_b;

    int n_chk;
    int n_err;
    int acc_a;
    int acc0;
    int n;

    lane_t exp_a[$];
    lane_t exp_b[$];
    wr_t   exp_wa[$];
    wr_t   wr_mon;
    logic [1:0] exp_addr_a;

    rmc_result_drain_if #(.NUM_LANES(8), .RES_WIDTH(8), .RES_DEPTH(4))  ifa ();
    rmc_result_drain_if #(.NUM_LANES(8), .RES_WIDTH(8), .RES_DEPTH(64)) ifb ();

    assign ifb.M_READY = 1'b1;

    rmc_result_drain #(
        .NUM_LANES(8), .DSPOUT_WIDTH(16), .RES_WIDTH(8), .SHIFT(0), .RES_DEPTH(4)
    ) dut_a (
        .CLK(CLK), .RSTN(RSTN), .PU_DONE(PU_DONE), .PU_OUT(PU_OUT), .CLR(CLR),
        .m_if(ifa.master), .BUSY(busy_a), .SAT_FLAG(sat_a), .DROP_ERR(drop_a)
    );

    rmc_result_drain #(
        .NUM_LANES(8), .DSPOUT_WIDTH(16), .RES_WIDTH(8), .SHIFT(4), .RES_DEPTH(64)
    ) dut_b (
        .CLK(CLK), .RSTN(RSTN), .PU_DONE(PU_DONE), .PU_OUT(PU_OUT), .CLR(CLR),
        .m_if(ifb.master), .BUSY(busy_b), .SAT_FLAG(sat_b), .DROP_ERR(drop_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference lane arithmetic: shift, then clamp to [-128, 127].
    function automatic logic [7:0] model(input int v, input int sh);
        int y;
        y = v >>> sh;
        if (y > 127) y = 127;
        else if (y < -128) y = -128;
        return 8'(y);
    endfunction

    function automatic logic [127:0] mkrow(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic push_row(input logic [127:0] row);
        logic [63:0] wd;
        lane_t       e;
        int          v;
        wd = '0;
        for (int j = 0; j < 8; j++) begin
            v      = 32'($signed(row[j*16 +: 16]));
            e.data = model(v, 0);
            e.last = (j == 7);
            exp_a.push_back(e);
            wd[j*8 +: 8] = e.data;
            e.data = model(v, 4);
            exp_b.push_back(e);
        end
        exp_wa.push_back('{addr: exp_addr_a, data: wd});
        exp_addr_a = exp_addr_a + 2'd1;
    endtask

    // Raise DONE after one idle edge; returns #1 after the capture edge.
    task automatic start_row(input logic [127:0] row, input logic clr_too);
        @(posedge CLK); #1;
        PU_OUT = row;
        push_row(row);
        PU_DONE = 1'b1;
        CLR = clr_too;
        @(posedge CLK); #1;
        CLR = 1'b0;
        chk("latency_valid", 64'(ifa.M_VALID), 64'd1);
        chk("latency_busy", 64'(busy_a), 64'd1);
    endtask

    task automatic wait_idle(input int maxc, output int cyc);
        cyc = 0;
        while (busy_a && cyc < maxc) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("idle_timeout", 64'(busy_a), 64'd0);
    endtask

    task automatic pulse_clr();
        @(posedge CLK); #1;
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
    endtask

    // Stream and write scoreboards, sampled mid-cycle.
    always @(negedge CLK) begin
        if (ifa.M_VALID) begin
            if (exp_a.size() == 0) begin
                chk("a_unexp_valid", 64'(ifa.M_VALID), 64'd0);
            end else begin
                chk("a_data", 64'($unsigned(ifa.M_DATA)), 64'(exp_a[0].data));
                chk("a_last", 64'(ifa.M_LAST), 64'(exp_a[0].last));
                if (ifa.M_READY) begin
                    void'(exp_a.pop_front());
                    acc_a++;
                end
            end
        end
        if (ifb.M_VALID) begin
            if (exp_b.size() == 0) begin
                chk("b_unexp_valid", 64'(ifb.M_VALID), 64'd0);
            end else begin
                chk("b_data", 64'($unsigned(ifb.M_DATA)), 64'(exp_b[0].data));
                chk("b_last", 64'(ifb.M_LAST), 64'(exp_b[0].last));
                void'(exp_b.pop_front());
            end
        end
        if (ifa.WR_EN) begin
            if (exp_wa.size() == 0) begin
                chk("a_unexp_wr", 64'(ifa.WR_EN), 64'd0);
            end else begin
                wr_mon = exp_wa.pop_front();
                chk("a_wr_addr", 64'(ifa.WR_ADDR), 64'(wr_mon.addr));
                chk("a_wr_data", ifa.WR_DATA, wr_mon.data);
            end
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        acc_a = 0;
        exp_addr_a = 2'd0;
        RSTN = 1'b0;
        PU_DONE = 1'b0;
        PU_OUT = '0;
        CLR = 1'b0;
        ifa.M_READY = 1'b1;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", 64'(ifa.M_VALID), 64'd0);
        chk("rst_last", 64'(ifa.M_LAST), 64'd0);
        chk("rst_data", 64'($unsigned(ifa.M_DATA)), 64'd0);
        chk("rst_wr_en", 64'(ifa.WR_EN), 64'd0);
        chk("rst_wr_addr", 64'(ifa.WR_ADDR), 64'd0);
        chk("rst_wr_data", ifa.WR_DATA, 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_sat", 64'(sat_a), 64'd0);
        chk("rst_drop", 64'(drop_a), 64'd0);
        RSTN = 1'b1;

        // 1: lanes 1..8, ready held high, NUM_LANES+1 busy cycles after capture
        start_row(mkrow(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
        PU_DONE = 1'b0;
        wait_idle(40, n);
        chk("t1_busy_cycles", 64'(n), 64'd9);
        chk("t1_sat", 64'(sat_a), 64'd0);
        chk("t1_q_empty", 64'(exp_a.size()), 64'd0);

        // 2: +-300 saturate; CLR coinciding with the set loses
        start_row(mkrow(300, -300, 0, 0, 0, 0, 0, 0), 1'b1);
        PU_DONE = 1'b0;
        chk("t2_sat_set_wins", 64'(sat_a), 64'd1);
        chk("t2_b_no_sat", 64'(sat_b), 64'd0);
        wait_idle(40, n);
        pulse_clr();
        chk("t2_sat_cleared", 64'(sat_a), 64'd0);

        // 3: SHIFT=4 instance rounding toward -inf and clamping
        start_row(mkrow(32'h0123, -16, 32767, -32768, 2032, 2048, -2048, -2049), 1'b0);
        PU_DONE = 1'b0;
        chk("t3_sat_b", 64'(sat_b), 64'd1);
        wait_idle(40, n);
        chk("t3_b_q_empty", 64'(exp_b.size()), 64'd0);
        pulse_clr();

        // 4: ready alternating 1,0,1,0: each lane held until accepted
        acc0 = acc_a;
        start_row(mkrow(-1, 2, -3, 4, -5, 6, -7, 8), 1'b0);
        PU_DONE = 1'b0;
        for (int c = 0; c < 40 && busy_a; c++) begin
            ifa.M_READY = ~ifa.M_READY;
            @(posedge CLK); #1;
        end
        ifa.M_READY = 1'b1;
        wait_idle(40, n);
        chk("t4_accepted", 64'(acc_a - acc0), 64'd8);
        chk("t4_q_empty", 64'(exp_a.size()), 64'd0);

        // 5a: DONE held 20 cycles gives exactly one drain (address wraps to 0)
        acc0 = acc_a;
        start_row(mkrow(100, -100, 50, -50, 25, -25, 12, -12), 1'b0);
        repeat (19) @(posedge CLK);
        #1;
        chk("t5a_no_drop", 64'(drop_a), 64'd0);
        chk("t5a_idle", 64'(busy_a), 64'd0);
        chk("t5a_accepted", 64'(acc_a - acc0), 64'd8);
        PU_DONE = 1'b0;

        // 5b: second rise during SEND is dropped
        acc0 = acc_a;
        start_row(mkrow(1, 1, 2, 3, 5, 8, 13, 21), 1'b0);
        PU_DONE = 1'b0;
        @(posedge CLK); #1;
        PU_DONE = 1'b1;
        @(posedge CLK); #1;
        chk("t5b_drop", 64'(drop_a), 64'd1);
        PU_DONE = 1'b0;
        wait_idle(40, n);
        repeat (12) @(posedge CLK);
        #1;
        chk("t5b_accepted", 64'(acc_a - acc0), 64'd8);
        chk("t5b_idle", 64'(busy_a), 64'd0);
        pulse_clr();
        chk("t5b_drop_cleared", 64'(drop_a), 64'd0);

        // 5c: rise on the WRITE->IDLE edge is a drop
        start_row(mkrow(7, 6, 5, 4, 3, 2, 1, 0), 1'b0);
        PU_DONE = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("t5c_in_write", 64'(ifa.WR_EN), 64'd1);
        PU_DONE = 1'b1;
        @(posedge CLK); #1;
        chk("t5c_drop", 64'(drop_a), 64'd1);
        chk("t5c_no_restart", 64'(ifa.M_VALID), 64'd0);
        PU_DONE = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("t5c_idle", 64'(busy_a), 64'd0);
        pulse_clr();

        // 6: reset during SEND at lane 3 abandons the row
        start_row(mkrow(11, 12, 13, 14, 15, 16, 17, 18), 1'b0);
        PU_DONE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RSTN = 1'b0;
        #1;
        chk("t6_valid", 64'(ifa.M_VALID), 64'd0);
        chk("t6_wr_en", 64'(ifa.WR_EN), 64'd0);
        chk("t6_wr_addr", 64'(ifa.WR_ADDR), 64'd0);
        chk("t6_busy", 64'(busy_a), 64'd0);
        chk("t6_lanes_sent", 64'(exp_a.size()), 64'd5);
        exp_a.delete();
        exp_b.delete();
        exp_wa.delete();
        exp_addr_a = 2'd0;
        repeat (3) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        start_row(mkrow(21, 22, 23, 24, 25, 26, 27, 28), 1'b0);
        PU_DONE = 1'b0;
        wait_idle(40, n);
        chk("t6_q_empty", 64'(exp_a.size()), 64'd0);
        chk("t6_wr_q_empty", 64'(exp_wa.size()), 64'd0);

        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
